// File: rtl/bsg_manycore_lock_client_pkg.sv
// bsg_manycore_lock_client_pkg: FSM states and lock reply encoding shared with the responder
package bsg_manycore_lock_client_pkg;
  typedef enum logic [2:0] {IDLE, SEND, WAIT, BACKOFF, RESP} state_e;
  localparam logic lock_success_gp = 1'b0;
  localparam logic lock_fail_gp = 1'b1;
endpackage

// File: rtl/bsg_manycore_lock_client_if.sv
// bsg_manycore_lock_client_if: core request/response, outgoing packet and returning-data bundle
interface bsg_manycore_lock_client_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4
);
  logic req_v_i, req_ready_o, req_acquire_i;
  logic [addr_width_p-1:0] req_addr_i;
  logic [x_cord_width_p-1:0] req_x_cord_i;
  logic [y_cord_width_p-1:0] req_y_cord_i;
  logic resp_v_o, resp_yumi_i, resp_success_o;
  logic [15:0] resp_tries_o;
  logic out_v_o, out_ready_i, out_swap_aq_o, out_swap_rl_o;
  logic [addr_width_p-1:0] out_addr_o;
  logic [x_cord_width_p-1:0] out_x_cord_o;
  logic [y_cord_width_p-1:0] out_y_cord_o;
  logic [data_width_p-1:0] out_data_o;
  logic returned_v_i;
  logic [data_width_p-1:0] returned_data_i;
  modport slave (
    input req_v_i, req_acquire_i, req_addr_i, req_x_cord_i, req_y_cord_i, resp_yumi_i,
          out_ready_i, returned_v_i, returned_data_i,
    output req_ready_o, resp_v_o, resp_success_o, resp_tries_o, out_v_o, out_addr_o,
           out_x_cord_o, out_y_cord_o, out_data_o, out_swap_aq_o, out_swap_rl_o
  );
  modport master (
    output req_v_i, req_acquire_i, req_addr_i, req_x_cord_i, req_y_cord_i, resp_yumi_i,
           out_ready_i, returned_v_i, returned_data_i,
    input req_ready_o, resp_v_o, resp_success_o, resp_tries_o, out_v_o, out_addr_o,
          out_x_cord_o, out_y_cord_o, out_data_o, out_swap_aq_o, out_swap_rl_o
  );
endinterface

// File: rtl/bsg_manycore_lock_backoff.sv
// bsg_manycore_lock_backoff: doubling backoff length and down-counter; LFSR jitter under BSG_MANYCORE_LOCK_CLIENT_JITTER_EN
module bsg_manycore_lock_backoff #(
  parameter int backoff_min_p = 4,
  parameter int backoff_max_p = 256,
  localparam int w = $clog2(backoff_max_p) + 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic reset_len_i,
  input  logic load_i,
  output logic done_o
`ifdef BSG_MANYCORE_LOCK_CLIENT_JITTER_EN
  , input logic [7:0] seed_i
`endif
);
  logic [w-1:0] len_q, len_d, cnt_q, cnt_d, jit, dbl;
`ifdef BSG_MANYCORE_LOCK_CLIENT_JITTER_EN
  localparam int jb = $clog2(backoff_min_p);
  logic [7:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign jit = w'(lfsr_q) & w'((1 << jb) - 1);
  always_ff @(posedge clk_i)
    lfsr_q <= reset_i ? ((seed_i == 8'd0) ? 8'd1 : seed_i) : lfsr_d;
`else
  assign jit = '0;
`endif
  always_comb begin
    dbl = len_q << 1;
    len_d = reset_len_i ? w'(backoff_min_p)
          : load_i ? ((dbl > w'(backoff_max_p)) ? w'(backoff_max_p) : dbl)
          : len_q;
    cnt_d = load_i ? len_q + jit : (cnt_q != '0) ? cnt_q - w'(1) : cnt_q;
  end
  assign done_o = cnt_q == w'(1);
  always_ff @(posedge clk_i)
    if (reset_i) begin
      len_q <= w'(backoff_min_p);
      cnt_q <= '0;
    end else begin
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/bsg_manycore_lock_client.sv
// bsg_manycore_lock_client: swap.aq/swap.rl mutex initiator with retry backoff; BSG_MANYCORE_LOCK_CLIENT_JITTER_EN adds LFSR jitter
module bsg_manycore_lock_client
  import bsg_manycore_lock_client_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int max_tries_p = 16,
  parameter int backoff_min_p = 4,
  parameter int backoff_max_p = 256
) (
  input logic clk_i,
  input logic reset_i,
  bsg_manycore_lock_client_if.slave io
);
  state_e state_q, state_d;
  logic acq_q, acq_d, held_q, held_d, success_q, success_d, reset_len, load, done;
  logic [addr_width_p-1:0] addr_q, addr_d;
  logic [x_cord_width_p-1:0] x_q, x_d;
  logic [y_cord_width_p-1:0] y_q, y_d;
  logic [15:0] tries_q, tries_d;
  logic unused_data;
  assign unused_data = ^io.returned_data_i[data_width_p-1:1];
  bsg_manycore_lock_backoff #(.backoff_min_p(backoff_min_p), .backoff_max_p(backoff_max_p)) backoff (
    .clk_i(clk_i), .reset_i(reset_i), .reset_len_i(reset_len), .load_i(load), .done_o(done)
`ifdef BSG_MANYCORE_LOCK_CLIENT_JITTER_EN
    , .seed_i(8'({io.req_x_cord_i, io.req_y_cord_i}))
`endif
  );
  always_comb begin
    state_d = state_q;
    acq_d = acq_q;
    addr_d = addr_q;
    x_d = x_q;
    y_d = y_q;
    held_d = held_q;
    tries_d = tries_q;
    success_d = success_q;
    reset_len = 1'b0;
    load = 1'b0;
    case (state_q)
      IDLE: if (io.req_v_i) begin
        acq_d = io.req_acquire_i;
        addr_d = io.req_addr_i;
        x_d = io.req_x_cord_i;
        y_d = io.req_y_cord_i;
        tries_d = '0;
        success_d = 1'b0;
        reset_len = 1'b1;
        // only one lock per tile: a second acquire fails without touching the network
        state_d = (io.req_acquire_i && held_q) ? RESP : SEND;
      end
      SEND: if (io.out_ready_i) begin
        tries_d = (acq_q && tries_q != 16'hffff) ? tries_q + 16'd1 : tries_q;
        state_d = WAIT;
      end
      WAIT: if (io.returned_v_i) begin
        if (!acq_q) begin
          held_d = 1'b0;
          success_d = 1'b1;
          state_d = RESP;
        end else if (io.returned_data_i[0] == lock_success_gp) begin
          held_d = 1'b1;
          success_d = 1'b1;
          state_d = RESP;
        end else if (io.returned_data_i[0] == lock_fail_gp && max_tries_p != 0
                     && tries_q == 16'(max_tries_p)) begin
          success_d = 1'b0;
          state_d = RESP;
        end else begin
          load = 1'b1;
          state_d = BACKOFF;
        end
      end
      BACKOFF: state_d = done ? SEND : BACKOFF;
      RESP: state_d = io.resp_yumi_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      state_q <= IDLE;
      acq_q <= 1'b0;
      addr_q <= '0;
      x_q <= '0;
      y_q <= '0;
      held_q <= 1'b0;
      tries_q <= '0;
      success_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acq_q <= acq_d;
      addr_q <= addr_d;
      x_q <= x_d;
      y_q <= y_d;
      held_q <= held_d;
      tries_q <= tries_d;
      success_q <= success_d;
    end
  assign io.req_ready_o = state_q == IDLE;
  assign io.resp_v_o = state_q == RESP;
  assign io.resp_success_o = success_q;
  assign io.resp_tries_o = tries_q;
  assign io.out_v_o = state_q == SEND;
  assign io.out_addr_o = addr_q;
  assign io.out_x_cord_o = x_q;
  assign io.out_y_cord_o = y_q;
  assign io.out_data_o = '0;
  assign io.out_swap_aq_o = (state_q == SEND) && acq_q;
  assign io.out_swap_rl_o = (state_q == SEND) && !acq_q;
endmodule

// File: tb/tb_bsg_manycore_lock_client.sv
// tb_bsg_manycore_lock_client: directed and random lock operations against a transaction-level lock model
module tb_bsg_manycore_lock_client;
  localparam int AW = 32, DW = 32, XW = 4, YW = 4, MAXT = 5, BMIN = 4, BMAX = 16;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  bit held = 1'b0;
  always #5 clk = ~clk;
  bsg_manycore_lock_client_if #(.addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW)) io ();
  bsg_manycore_lock_client #(.addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .max_tries_p(MAXT), .backoff_min_p(BMIN), .backoff_max_p(BMAX)) dut (.clk_i(clk), .reset_i(rst), .io(io.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input bit succ, input int tries);
    int w = $urandom_range(0, 2);
    chk("resp_v", io.resp_v_o, 1);
    chk("resp_success", io.resp_success_o, succ);
    chk("resp_tries", io.resp_tries_o, tries);
    chk("resp_no_pkt", io.out_v_o, 0);
    for (int i = 0; i < w; i++) begin
      io.resp_yumi_i = 1'b0;
      io.req_v_i = 1'($urandom);
      io.req_acquire_i = 1'($urandom);
      io.returned_v_i = 1'($urandom);
      tick();
      chk("resp_hold", {io.resp_v_o, io.req_ready_o}, 2'b10);
      chk("resp_hold_success", io.resp_success_o, succ);
      chk("resp_hold_tries", io.resp_tries_o, tries);
    end
    io.resp_yumi_i = 1'b1;
    io.req_v_i = 1'b1;
    io.req_acquire_i = 1'($urandom);
    tick();
    io.resp_yumi_i = 1'b0;
    io.req_v_i = 1'b0;
    io.returned_v_i = 1'b0;
    chk("back_to_idle", {io.out_v_o, io.resp_v_o, io.req_ready_o}, 3'b001);
    tick();
    chk("yumi_req_not_taken", {io.out_v_o, io.resp_v_o, io.req_ready_o}, 3'b001);
  endtask

  task automatic run_op(input bit acq, input logic [15:0] rep, input int stall);
    logic [AW-1:0] a = AW'($urandom);
    logic [XW-1:0] x = XW'($urandom);
    logic [YW-1:0] y = YW'($urandom);
    int tries = 0, len = BMIN, k = 0, d;
    bit fin = 1'b0;
    chk("req_ready", io.req_ready_o, 1);
    io.req_v_i = 1'b1;
    io.req_acquire_i = acq;
    io.req_addr_i = a;
    io.req_x_cord_i = x;
    io.req_y_cord_i = y;
    tick();
    io.req_v_i = 1'b0;
    io.req_addr_i = AW'($urandom);
    io.req_x_cord_i = XW'($urandom);
    io.req_y_cord_i = YW'($urandom);
    if (acq && held) begin
      chk("held_no_pkt", io.out_v_o, 0);
      expect_resp(1'b0, 0);
      return;
    end
    while (!fin) begin
      for (int i = 0; i <= stall; i++) begin
        io.out_ready_i = (i == stall);
        chk("out_v", io.out_v_o, 1);
        chk("out_addr", io.out_addr_o, a);
        chk("out_x", io.out_x_cord_o, x);
        chk("out_y", io.out_y_cord_o, y);
        chk("out_aq", io.out_swap_aq_o, acq);
        chk("out_rl", io.out_swap_rl_o, !acq);
        chk("out_data", io.out_data_o, 0);
        tick();
      end
      io.out_ready_i = 1'($urandom);
      if (acq) tries++;
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        chk("wait_quiet", {io.out_v_o, io.resp_v_o}, 2'b00);
        tick();
      end
      chk("wait_sent_once", io.out_v_o, 0);
      io.returned_v_i = 1'b1;
      io.returned_data_i = {31'($urandom), rep[k]};
      tick();
      io.returned_v_i = 1'b0;
      io.returned_data_i = DW'($urandom);
      if (!acq) begin
        held = 1'b0;
        expect_resp(1'b1, 0);
        fin = 1'b1;
      end else if (!rep[k]) begin
        held = 1'b1;
        expect_resp(1'b1, tries);
        fin = 1'b1;
      end else if (tries == MAXT) begin
        expect_resp(1'b0, tries);
        fin = 1'b1;
      end else begin
        for (int j = 0; j < len; j++) begin
          chk("backoff_quiet", {io.out_v_o, io.resp_v_o}, 2'b00);
          tick();
        end
        len = (2 * len > BMAX) ? BMAX : 2 * len;
      end
      k++;
    end
  endtask

  task automatic reset_in_wait();
    chk("rw_ready", io.req_ready_o, 1);
    io.req_v_i = 1'b1;
    io.req_acquire_i = 1'b0;
    tick();
    io.req_v_i = 1'b0;
    chk("rw_out_rl", {io.out_v_o, io.out_swap_rl_o}, 2'b11);
    io.out_ready_i = 1'b1;
    tick();
    io.out_ready_i = 1'b0;
    chk("rw_in_wait", io.out_v_o, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    held = 1'b0;
    chk("rw_reset_state", {io.req_ready_o, io.resp_v_o, io.out_v_o, io.resp_success_o}, 4'b1000);
    chk("rw_reset_tries", io.resp_tries_o, 0);
    io.returned_v_i = 1'b1;
    io.returned_data_i = '0;
    tick();
    io.returned_v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rw_stale_ignored", {io.out_v_o, io.resp_v_o, io.req_ready_o}, 3'b001);
      tick();
    end
  endtask

  initial begin
    io.req_v_i = 1'b0;
    io.req_acquire_i = 1'b0;
    io.req_addr_i = '0;
    io.req_x_cord_i = '0;
    io.req_y_cord_i = '0;
    io.resp_yumi_i = 1'b0;
    io.out_ready_i = 1'b0;
    io.returned_v_i = 1'b0;
    io.returned_data_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_ready", io.req_ready_o, 1);
    chk("rst_outs", {io.resp_v_o, io.out_v_o, io.out_swap_aq_o, io.out_swap_rl_o, io.resp_success_o}, 5'b0);
    chk("rst_tries", io.resp_tries_o, 0);
    run_op(1'b1, 16'h0000, 0);
    run_op(1'b1, 16'h0000, 0);
    run_op(1'b0, 16'h0000, 5);
    run_op(1'b1, 16'h0003, 0);
    run_op(1'b0, 16'h0000, 1);
    run_op(1'b1, 16'h001f, 0);
    run_op(1'b0, 16'h0000, 0);
    run_op(1'b1, 16'h0000, 2);
    reset_in_wait();
    run_op(1'b1, 16'h0000, 0);
    for (int n = 0; n < 40; n++)
      run_op($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 2));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bsg_manycore_lock_client.md
# bsg_manycore_lock_client

Core-side initiator for the manycore mutex protocol: converts a single acquire/release request from a tile into remote `swap.aq` / `swap.rl` packets toward the lock-owning endpoint. It interprets the returned word (0 = acquired, 1 = busy) and retries failed acquires with exponential backoff until success or a try limit. It sits between the core's remote-request path and the endpoint's outgoing request/returning-data interface.

## Interface
- `addr_width_p`, 32, remote word address width
- `data_width_p`, 32, packet data width; the request data field is driven to 0
- `x_cord_width_p`, "inv", destination X width
- `y_cord_width_p`, "inv", destination Y width
- `max_tries_p`, 16, acquire attempts before reporting fail; 0 = retry forever
- `backoff_min_p`, 4, first backoff length in cycles (>=1)
- `backoff_max_p`, 256, backoff saturation value; power of two, >= `backoff_min_p`

Ports:
- `clk_i` in 1: clock
- `reset_i` in 1: synchronous, active-high reset
- `req_v_i` in 1: core request valid
- `req_ready_o` out 1: request accepted when `req_v_i & req_ready_o`
- `req_acquire_i` in 1: 1 = acquire, 0 = release
- `req_addr_i` in `addr_width_p`: lock address
- `req_x_cord_i` in `x_cord_width_p`: lock owner X
- `req_y_cord_i` in `y_cord_width_p`: lock owner Y
- `resp_v_o` out 1: completion valid
- `resp_yumi_i` in 1: core consumes completion
- `resp_success_o` out 1: 1 = lock acquired / released
- `resp_tries_o` out 16: acquire attempts used, saturating
- `out_v_o` out 1: packet valid
- `out_ready_i` in 1: network accepts packet
- `out_addr_o`, `out_x_cord_o`, `out_y_cord_o` out: latched target
- `out_data_o` out `data_width_p`: constant 0
- `out_swap_aq_o`, `out_swap_rl_o` out 1: opcode; exactly one high while `out_v_o`
- `returned_v_i` in 1: returning word valid, single-cycle pulse, no backpressure
- `returned_data_i` in `data_width_p`: bit 0 is the lock result

## Operation
- FSM: IDLE, SEND, WAIT, BACKOFF, RESP.
- IDLE: `req_ready_o`=1. On accept, latch addr/x/y/opcode; clear try count; set backoff to `backoff_min_p`. Acquire with `held_r`=1 → RESP with fail and no packet (one lock per tile). Otherwise → SEND.
- SEND: `out_v_o`=1 with the latched fields, held stable until `out_ready_i`. Acquire increments tries (saturating at 0xFFFF). → WAIT.
- WAIT: on `returned_v_i`:
  - Release: clear `held_r`; success=1; → RESP.
  - Acquire with bit0=0: set `held_r`; success=1; → RESP.
  - Acquire with bit0=1 and `tries == max_tries_p` (`max_tries_p` ≠ 0): success=0; → RESP.
  - Otherwise: load the backoff counter with the current length and double the length, saturating at `backoff_max_p`; → BACKOFF.
- BACKOFF: counter decrements each cycle; at 1 → SEND.
- RESP: `resp_v_o`=1 until `resp_yumi_i`, then → IDLE.
- Release with `held_r`=0 is still sent (the responder releases unconditionally).
- A `returned_v_i` outside WAIT is ignored.

## Timing
- Reset: state=IDLE, `held_r`=0, tries=0. Outputs: `req_ready_o`=1, `resp_v_o`=0, `out_v_o`=0, opcode bits 0, `resp_success_o`=0, `resp_tries_o`=0.
- Reset mid-operation aborts the operation. The in-flight reply is dropped by the outside-WAIT rule, and `held_r` is cleared.
- Accept → `out_v_o` on the next cycle. Return in WAIT cycle N → `resp_v_o` at N+1, or BACKOFF starting at N+1.
- A failed attempt occupies exactly `len` BACKOFF cycles, then `out_v_o` rises on the following cycle.
- Simultaneous `resp_yumi_i` and a new `req_v_i`: the request is not accepted that cycle; `req_ready_o` is registered from state.

## Configuration
- `BSG_MANYCORE_LOCK_CLIENT_JITTER_EN`: when defined, an 8-bit LFSR is seeded from `{x,y}` at reset. Its low `$clog2(backoff_min_p)` bits are added to each loaded backoff value to decorrelate contending tiles.
- When not defined, backoff is deterministic: `backoff_min_p`, ×2, …, up to `backoff_max_p`.

## Structure
- Package `bsg_manycore_lock_client_pkg` holds:
  - the FSM state enum;
  - `lock_success_gp` = 1'b0 and `lock_fail_gp` = 1'b1, shared with the responder side.
- Sub-module `bsg_manycore_lock_backoff` holds the length register, the down-counter and the optional LFSR. It has load/done signals and a `reset_len` input.

## Test plan
- Acquire on a free lock (reply 0 one cycle after SEND) → `resp_v_o` with success=1, tries=1, `held_r`=1.
- Acquire with replies 1,1,0; `backoff_min_p`=4; jitter off → BACKOFF gaps of 4 and then 8 cycles; success with tries=3.
- `max_tries_p`=2, replies 1,1 → exactly 2 packets sent, then fail with tries=2, and `held_r` stays 0.
- Second acquire while held → immediate fail, `out_v_o` never asserted; a release then sends `swap_rl` with addr equal to the latched value.
- `out_ready_i` low for 5 cycles in SEND → address and opcode stay stable for all 5 cycles, and the packet is sent exactly once.
- Reset asserted in WAIT, then a stale `returned_v_i`=1 → ignored: state stays IDLE and `resp_v_o` stays 0.
